// File: rtl/polar_mag_sqrt.sv
// Exact integer square root for the polar-conversion datapath:
// restoring digit-by-digit, one root bit per enabled clock, valid/ready on both sides.
module polar_mag_sqrt #(
    parameter int unsigned IN_W = 17
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               sum_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [(IN_W+1)/2-1:0]         root_out,
    output logic [(IN_W+1)/2:0]           rem_out,
    output logic                          exact_out
);

    localparam int unsigned OUT_W = (IN_W + 1) / 2;
    localparam int unsigned OP_W  = 2 * OUT_W;
    localparam int unsigned REM_W = OUT_W + 2;
    localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OP_W-1:0]    op_q;
    logic [REM_W-1:0]   rem_q;
    logic [OUT_W-1:0]   root_q;

    logic               out_valid_q;
    logic [OUT_W-1:0]   root_out_q;
    logic [OUT_W:0]     rem_out_q;
    logic               exact_out_q;

    logic [REM_W-1:0]   rem_sh;
    logic [REM_W-1:0]   trial;
    logic [REM_W-1:0]   rem_d;
    logic [OUT_W-1:0]   root_d;

    // Held off during reset so no operand is taken before the FSM is live.
    assign in_ready = rst_n && ena && (state_q == IDLE);

    // One restoring iteration: bring down two operand bits, try subtracting 4*root+1.
    always_comb begin
        rem_sh = (rem_q << 2) | REM_W'(op_q[OP_W-1 -: 2]);
        trial  = (REM_W'(root_q) << 2) | REM_W'(1);
        rem_d  = rem_sh;
        root_d = root_q << 1;
        if (rem_sh >= trial) begin
            rem_d  = rem_sh - trial;
            root_d = (root_q << 1) | OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            out_valid_q <= 1'b0;
            root_out_q  <= '0;
            rem_out_q   <= '0;
            exact_out_q <= 1'b0;
        end else if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= OP_W'(sum_in);
                        rem_q   <= '0;
                        root_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    op_q   <= op_q << 2;
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(OUT_W - 1)) begin
                        root_out_q  <= root_d;
                        rem_out_q   <= rem_d[OUT_W:0];
                        exact_out_q <= (rem_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign root_out  = root_out_q;
    assign rem_out   = rem_out_q;
    assign exact_out = exact_out_q;

endmodule

// File: tb/tb_polar_mag_sqrt.sv
// Directed self-checking bench for polar_mag_sqrt: known squares, boundaries,
// backpressure, enable stalls and mid-calculation reset.
module tb_polar_mag_sqrt;

    localparam int unsigned IN_W  = 17;
    localparam int unsigned OUT_W = 9;

    logic               clk;
    logic               rst_n;
    logic               ena;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    sum_in;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   root_out;
    logic [OUT_W:0]     rem_out;
    logic               exact_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    polar_mag_sqrt #(.IN_W(IN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root_out  (root_out),
        .rem_out   (rem_out),
        .exact_out (exact_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts enabled-or-not clocks after the accept edge until out_valid, bounded.
    task automatic wait_valid(output int unsigned n);
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic accept(input int unsigned v, input string tag);
        sum_in   = IN_W'(v);
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        sum_in   = '0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 0);
        check({tag, "_idle_ready"}, 32'(in_ready), 1);
    endtask

    task automatic run_op(input int unsigned v, input int unsigned e_root,
                          input int unsigned e_rem, input int unsigned e_exact,
                          input string tag);
        int unsigned lat;
        accept(v, tag);
        wait_valid(lat);
        check({tag, "_latency"}, lat, 9);
        check({tag, "_root"}, 32'(root_out), e_root);
        check({tag, "_rem"}, 32'(rem_out), e_rem);
        check({tag, "_exact"}, 32'(exact_out), e_exact);
        drain(tag);
    endtask

    initial begin
        int unsigned lat;
        int unsigned cnt_v;
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        sum_in    = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_root", 32'(root_out), 0);
        check("rst_rem", 32'(rem_out), 0);
        check("rst_exact", 32'(exact_out), 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(in_ready), 1);

        run_op(0,      0,   0,   1, "zero");
        run_op(25,     5,   0,   1, "sq25");
        run_op(24,     4,   8,   0, "n24");
        run_op(130050, 360, 450, 0, "max255");
        run_op(131071, 362, 27,  0, "allones");
        run_op(1,      1,   0,   1, "one");
        run_op(2,      1,   1,   0, "two");

        // Backpressure: result held while the consumer stalls.
        accept(1000, "bp");
        wait_valid(lat);
        check("bp_latency", lat, 9);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_hold", 32'(out_valid), 1);
            check("bp_root_hold", 32'(root_out), 31);
            check("bp_rem_hold", 32'(rem_out), 39);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        // Consumer ready while ena is low must not complete the handshake.
        out_ready = 1'b1;
        ena       = 1'b0;
        tick();
        check("bp_ena_low_valid", 32'(out_valid), 1);
        check("bp_ena_low_ready", 32'(in_ready), 0);
        ena = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 0);
        check("bp_release_ready", 32'(in_ready), 1);

        // Enable stall mid-calculation stretches latency by the stall length.
        accept(144, "stall");
        repeat (3) tick();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_valid", 32'(out_valid), 0);
        end
        ena = 1'b1;
        wait_valid(lat);
        check("stall_latency", lat + 6, 12);
        check("stall_root", 32'(root_out), 12);
        check("stall_rem", 32'(rem_out), 0);
        check("stall_exact", 32'(exact_out), 1);
        drain("stall");

        // Reset at CALC iteration 4 aborts the operation entirely.
        accept(200, "abort");
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("abort_valid", 32'(out_valid), 0);
        check("abort_root", 32'(root_out), 0);
        check("abort_rem", 32'(rem_out), 0);
        check("abort_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        cnt_v = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) cnt_v++;
        end
        check("abort_never_valid", cnt_v, 0);
        check("abort_root_after", 32'(root_out), 0);
        run_op(100, 10, 0, 1, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
